mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port unified memory between the instruction-fetch path and the
//  lw/sw data path of the 16-bit core. Arbitrates requests round-robin, sequences the
//  memory access through a fixed read latency, and returns read data to the winner.
//  Sits between control/datapath and the memory macro; replaces the fixed fetch/execute
//  phase split with a req/gnt handshake.
// PARAMETERS
//  ADDR_W   16  address width
//  DATA_W   16  data width
//  MEM_LAT  1   cycles from mem_en (read) to mem_rdata valid; legal range 1..7
// PORTS
//  clk        in   1       system clock, all state on posedge
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       fetch read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       1-cycle pulse: fetch request accepted and issued
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction word
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1       1 = store (sw), 0 = load (lw)
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse: data request accepted and issued
//  d_rvalid   out  1       1-cycle pulse: d_rdata valid (loads only)
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access strobe, 1 cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state IDLE; all out ports 0; latency counter 0; last_grant = FETCH.
//  - FSM: IDLE -> ISSUE -> (WAIT, reads) -> IDLE. All outputs registered.
//  - IDLE: sample if_req/d_req. None: stay. One: latch that requester's cmd -> ISSUE.
//    Both: winner = requester not granted last (round-robin); after reset data wins.
//  - ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata from latched cmd; winner's gnt=1;
//    last_grant updated. Write -> IDLE. Read -> WAIT, counter loaded with MEM_LAT.
//  - WAIT: counter decrements each cycle; in the cycle it reaches 0, capture mem_rdata
//    into winner's rdata, pulse winner's rvalid, -> IDLE. rdata holds until next capture.
//  - Latency: request seen in IDLE at cycle N -> gnt/mem_en at N+1 -> rvalid at
//    N+2+MEM_LAT. Write occupies 2 cycles; read occupies MEM_LAT+2 cycles.
//  - Requests arriving outside IDLE are not sampled; requester keeps req high.
//  - gnt and rvalid never asserted for both ports in the same cycle.
//  - Requester may drop req in the cycle after gnt; req still high then is a new request.
//  - d_rvalid never pulses for a store; if_we is implicitly 0.
//  - Reset mid-access (ISSUE/WAIT): access abandoned, no rvalid, outputs to reset values.
//  - Counter width $clog2(MEM_LAT+1); MEM_LAT out of range is a $error at elaboration.
// STRUCTURE
//  - Shared package (cpu_pkg): state encoding ST_IDLE/ST_ISSUE/ST_WAIT, port ids
//    PORT_FETCH/PORT_DATA, ADDR_W/DATA_W defaults.
//  - One sub-module natural: rr_arb2 (2-way round-robin picker, last_grant register).
//  - FSM, command latch and latency counter stay in mem_arbiter.
// TESTING
//  1 Reset: hold reset 2 cycles, both reqs high -> no gnt/mem_en/rvalid; after release
//    first conflict grants data.
//  2 Single fetch, MEM_LAT=1: if_req, if_addr=0x0010, mem returns 0xA5A5 -> if_gnt at
//    N+1 with mem_addr=0x0010, if_rvalid at N+3, if_rdata=0xA5A5.
//  3 Store: d_req, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> mem_en&mem_we at N+1 with
//    those values, d_gnt pulse, no d_rvalid, IDLE at N+2.
//  4 Contention: both reqs held high 6 accesses -> grants alternate D,F,D,F,D,F; no cycle
//    with both gnts or both rvalids.
//  5 MEM_LAT=3 load d_addr=0x0044 -> d_rvalid exactly 5 cycles after request sampled.
//  6 Reset asserted in WAIT -> no rvalid ever for that access; next request served
//    normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, port ids
// and default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. The requester that was not granted last wins a tie;
// a lone requester always wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_fetch,
  input  logic  req_data,
  input  logic  update,
  input  port_e grant_port,
  output logic  any,
  output port_e pick
);

  port_e last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_FETCH;
    end else if (update) begin
      last_grant <= grant_port;
    end
  end

  always_comb begin
    any  = req_fetch | req_data;
    pick = PORT_FETCH;
    if (req_fetch && req_data) begin
      pick = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (req_data) begin
      pick = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between instruction fetch and lw/sw,
// issuing one access at a time and returning read data after MEM_LAT cycles.
//
// state    | meaning
// ST_IDLE  | sample requests, latch winner's command, raise gnt/mem_en
// ST_ISSUE | access on the memory bus; writes finish here
// ST_WAIT  | count down read latency, capture mem_rdata at terminal count
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT=%0d outside 1..7", MEM_LAT);
    end
  endgenerate

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  port_e            cmd_port;
  logic             cmd_we;
  logic             arb_any;
  port_e            arb_pick;

  rr_arb2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .req_fetch  (if_req),
    .req_data   (d_req),
    .update     (state == ST_ISSUE),
    .grant_port (cmd_port),
    .any        (arb_any),
    .pick       (arb_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_port  <= PORT_FETCH;
      cmd_we    <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Command is latched straight onto the registered memory bus so that
          // gnt and mem_en appear together in the ISSUE cycle.
          if (arb_any) begin
            state    <= ST_ISSUE;
            cmd_port <= arb_pick;
            mem_en   <= 1'b1;
            if (arb_pick == PORT_DATA) begin
              cmd_we    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              d_gnt     <= 1'b1;
            end else begin
              cmd_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              if_gnt    <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_we) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(MEM_LAT);
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            if (cmd_port == PORT_DATA) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
